cdc_req_arb: RTL and testbench
==============================

CDC_REQ_ARB -- requirements
Module: cdc_req_arb

Interface
REQ-001 Parameter NREQ, 4, number of source-domain requesters (2..8).
REQ-002 Parameter DWIDTH, 32, payload width per requester.
REQ-003 Parameter TIMEOUT, 64, watchdog limit in i_clk cycles (1..65535); used only when CDC_ARB_TIMEOUT_EN is defined.
REQ-004 i_clk  input  1  single clock (source domain of the shared bus synchronizer).
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 i_req  input  NREQ  per-requester request level, held until acknowledged.
REQ-007 i_req_data  input  NREQ*DWIDTH  payloads; requester k occupies bits [k*DWIDTH +: DWIDTH].
REQ-008 o_ack  output  NREQ  one-hot, one-cycle pulse: payload k taken.
REQ-009 o_sync_data  output  DWIDTH  payload to the shared bus synchronizer.
REQ-010 o_sync_valid  output  1  one-cycle launch pulse to the synchronizer.
REQ-011 i_sync_ready  input  1  synchronizer free (high) / transfer in flight (low).
REQ-012 o_gnt_id  output  $clog2(NREQ)  index of the current/last granted requester.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_err  output  1  one-cycle timeout pulse; tied 0 when CDC_ARB_TIMEOUT_EN is undefined.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-016 IDLE: if i_sync_ready=1 and i_req!=0, select a winner, register its payload into o_sync_data, set o_gnt_id, go to ISSUE; otherwise stay in IDLE.
REQ-017 Selection: round-robin, searching upward from pointer ptr modulo NREQ; the first set bit wins.
REQ-018 ptr updates to (winner+1) mod NREQ in the cycle the winner is selected.
REQ-019 ISSUE: o_sync_valid=1 and o_ack[winner]=1 for exactly this cycle; next state is WAIT_LOW.
REQ-020 WAIT_LOW: stay until i_sync_ready=0 is sampled, then go to WAIT_HIGH.
REQ-021 WAIT_HIGH: stay until i_sync_ready=1 is sampled, then go to IDLE.
REQ-022 o_sync_data is stable from ISSUE until the FSM re-enters IDLE; it changes only on a new selection.
REQ-023 Latency: request seen in IDLE with ready high -> o_sync_valid 1 cycle later; minimum spacing between launches is 4 cycles.
REQ-024 A request deasserted before its ack is ignored; a request asserted while the FSM is busy waits for IDLE.
REQ-025 i_sync_ready=0 in IDLE blocks selection; ptr and o_sync_data hold.
REQ-026 At most one o_ack bit is set in any cycle; o_ack=0 outside ISSUE.
REQ-027 A single requester holding i_req continuously is granted once per full IDLE->IDLE cycle.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, ptr=0, o_sync_data=0, o_sync_valid=0, o_ack=0, o_gnt_id=0, o_busy=0, o_err=0, watchdog count=0.
REQ-029 Reset asserted mid-transfer aborts it without issuing a further o_sync_valid; the first launch after release follows REQ-016.

Configuration
REQ-030 Macro CDC_ARB_TIMEOUT_EN defined:
- a watchdog counts i_clk cycles spent in WAIT_LOW plus WAIT_HIGH;
- on reaching TIMEOUT, o_err pulses for 1 cycle, the FSM returns to IDLE, and the count clears;
- the count clears on every entry to ISSUE.
REQ-031 Macro undefined: no counter logic is built; o_err=0 constant; WAIT states wait indefinitely.

Verification
REQ-032 i_req=4'b0001, data0=32'hA5A5_0001, ready high, ready model low 3 cycles then high -> o_sync_valid and o_ack=0001 1 cycle after request; o_sync_data=A5A5_0001 stable until IDLE.
REQ-033 i_req=4'b1111 held, ready model as above -> ack order 0,1,2,3,0; o_gnt_id follows 0,1,2,3,0.
REQ-034 After reset ptr=0; i_req=4'b1010 -> requester 1 granted first, then requester 3.
REQ-035 i_sync_ready held 0 with i_req=0001 -> no o_sync_valid and o_busy=0; ready rises -> launch 1 cycle later.
REQ-036 CDC_ARB_TIMEOUT_EN defined, TIMEOUT=8, ready never returns high after the launch -> o_err pulses once, the FSM returns to IDLE, and the next pending request is served.
REQ-037 rst_n pulsed low while in WAIT_HIGH -> all outputs 0 immediately; after release, no launch occurs until a request is seen with ready high.

Source files
------------

// File: rtl/cdc_req_arb_if.sv
// rtl/cdc_req_arb_if.sv - requester/synchronizer bundle for cdc_req_arb.
// master = arbiter side, slave = requesters plus the shared bus synchronizer.
interface cdc_req_arb_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        i_req;
  logic [NREQ*DWIDTH-1:0] i_req_data;
  logic [NREQ-1:0]        o_ack;
  logic [DWIDTH-1:0]      o_sync_data;
  logic                   o_sync_valid;
  logic                   i_sync_ready;
  logic [IDW-1:0]         o_gnt_id;
  logic                   o_busy;
  logic                   o_err;

  modport master (
    input  i_req, i_req_data, i_sync_ready,
    output o_ack, o_sync_data, o_sync_valid, o_gnt_id, o_busy, o_err
  );

  modport slave (
    output i_req, i_req_data, i_sync_ready,
    input  o_ack, o_sync_data, o_sync_valid, o_gnt_id, o_busy, o_err
  );
endinterface

// File: rtl/cdc_req_arb.sv
// rtl/cdc_req_arb.sv - round-robin arbiter feeding one shared bus synchronizer.
// Optional WAIT-state watchdog built only when CDC_ARB_TIMEOUT_EN is defined.
module cdc_req_arb #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 64
) (
  input logic           i_clk,
  input logic           rst_n,
  cdc_req_arb_if.master bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_gnt_id;
  logic [DWIDTH-1:0] r_sync_data;
  logic [IDW-1:0]    w_win;
  logic [IDW-1:0]    w_ptr_nxt;
  logic              w_found;
  logic              w_launch;
  logic              w_timeout;
  logic [NREQ-1:0]   w_ack;

  // First set request at or above r_ptr, wrapping modulo NREQ.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && bus.i_req[j]) begin
        w_found = 1'b1;
        w_win   = IDW'(j);
      end
    end
  end

  assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  assign w_launch  = (r_state == IDLE) && bus.i_sync_ready && w_found;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_launch) w_next = ISSUE;
      ISSUE:     w_next = WAIT_LOW;
      WAIT_LOW:  if (w_timeout) w_next = IDLE;
                 else if (!bus.i_sync_ready) w_next = WAIT_HIGH;
      WAIT_HIGH: if (w_timeout || bus.i_sync_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_sync_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_ptr       <= w_ptr_nxt;
        r_gnt_id    <= w_win;
        r_sync_data <= bus.i_req_data[w_win*DWIDTH +: DWIDTH];
      end
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        w_waiting;

  assign w_waiting = (r_state == WAIT_LOW) || (r_state == WAIT_HIGH);
  // r_wdog holds cycles already spent waiting, so the TIMEOUT-th wait cycle fires.
  assign w_timeout = w_waiting && (r_wdog == 16'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == ISSUE || w_timeout) begin
      r_wdog <= '0;
    end else if (w_waiting) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign bus.o_err = w_timeout;
`else
  assign w_timeout = 1'b0;
  // TIMEOUT is only legal in 1..65535, so this is constant 0 in every build.
  assign bus.o_err = (TIMEOUT == 0);
`endif

  always_comb begin
    w_ack = '0;
    if (r_state == ISSUE) w_ack[r_gnt_id] = 1'b1;
  end

  assign bus.o_ack        = w_ack;
  assign bus.o_sync_valid = (r_state == ISSUE);
  assign bus.o_sync_data  = r_sync_data;
  assign bus.o_gnt_id     = r_gnt_id;
  assign bus.o_busy       = (r_state != IDLE);
endmodule

// File: tb/tb_cdc_req_arb.sv
// tb/tb_cdc_req_arb.sv - scoreboard bench for cdc_req_arb.
// Directed grants are queued by the stimulus and popped by a monitor on each launch.
module tb_cdc_req_arb;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TO   = 8;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_en = 1'b1;
  exp_t sb[$];

  always #5 clk = ~clk;

  cdc_req_arb_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

  cdc_req_arb #(.NREQ(NREQ), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] pay(input int k);
    return 32'hA5A5_0001 + 32'(k);
  endfunction

  function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function void expect_grant(input int k);
    exp_t e;
    e.id   = 2'(k);
    e.data = pay(k);
    sb.push_back(e);
  endfunction

  // Monitor: pops one expectation per launch and checks ack/data around it.
  initial begin
    exp_t        e;
    logic [31:0] held;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_sync_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_launch", 64'(bus.o_gnt_id), 64'hFF);
          end else begin
            e = sb.pop_front();
            check("ack", 64'(bus.o_ack), 64'(1) << e.id);
            check("gnt_id", 64'(bus.o_gnt_id), 64'(e.id));
            check("sync_data", 64'(bus.o_sync_data), 64'(e.data));
          end
          held = bus.o_sync_data;
        end else begin
          check("ack_outside_issue", 64'(bus.o_ack), 64'd0);
          if (bus.o_busy) check("data_stable", 64'(bus.o_sync_data), 64'(held));
        end
`ifndef CDC_ARB_TIMEOUT_EN
        check("err_tied_low", 64'(bus.o_err), 64'd0);
`endif
      end
    end
  end

  // Synchronizer model: busy for 3 cycles after each launch.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && rst_n && bus.o_sync_valid) begin
        bus.i_sync_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_sync_ready = 1'b1;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.o_sync_valid), 64'd0);
    check({tag, "_ack"}, 64'(bus.o_ack), 64'd0);
    check({tag, "_data"}, 64'(bus.o_sync_data), 64'd0);
    check({tag, "_gnt"}, 64'(bus.o_gnt_id), 64'd0);
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    check({tag, "_err"}, 64'(bus.o_err), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.o_sync_valid && cyc < 40);
    if (!bus.o_sync_valid) check("launch_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (bus.o_busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.o_busy) check("idle_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic run(input logic [3:0] req, input int n);
    int c;
    bus.i_req = req;
    for (int i = 0; i < n; i++) wait_valid(c);
    bus.i_req = '0;
    wait_idle();
  endtask

  initial begin
    int c;
    bus.i_req        = '0;
    bus.i_sync_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) bus.i_req_data[k*DW +: DW] = pay(k);

    // Single requester: launch one cycle after the request.
    do_reset();
    expect_grant(0);
    bus.i_req = 4'b0001;
    wait_valid(c);
    check("latency_single", 64'(c), 64'd1);
    bus.i_req = '0;
    wait_idle();

    // All requesters held: round-robin 0,1,2,3,0.
    do_reset();
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
    run(4'b1111, 5);

    // Pointer 0 after reset, sparse requests: 1 then 3.
    do_reset();
    expect_grant(1); expect_grant(3);
    run(4'b1010, 2);

    // Ready low in IDLE blocks selection.
    do_reset();
    bus.i_sync_ready = 1'b0;
    bus.i_req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("blocked_valid", 64'(bus.o_sync_valid), 64'd0);
      check("blocked_busy", 64'(bus.o_busy), 64'd0);
    end
    expect_grant(0);
    bus.i_sync_ready = 1'b1;
    wait_valid(c);
    check("latency_after_ready", 64'(c), 64'd1);
    bus.i_req = '0;
    wait_idle();

    // Reset while in WAIT_HIGH aborts the transfer.
    do_reset();
    expect_grant(0);
    bus.i_req = 4'b0001;
    wait_valid(c);
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    check("busy_in_wait_high", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_launch_after_reset", 64'(bus.o_busy), 64'd0);
    expect_grant(2);
    bus.i_req = 4'b0100;
    wait_valid(c);
    check("latency_post_reset", 64'(c), 64'd1);
    bus.i_req = '0;
    wait_idle();

`ifdef CDC_ARB_TIMEOUT_EN
    // Synchronizer never returns ready: watchdog fires after TO wait cycles.
    do_reset();
    model_en = 1'b0;
    expect_grant(0);
    bus.i_req = 4'b0001;
    wait_valid(c);
    bus.i_req = 4'b0010;
    bus.i_sync_ready = 1'b0;
    expect_grant(1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.o_err && c < 30);
    check("timeout_cycles", 64'(c), 64'(TO));
    @(negedge clk);
    check("err_single_pulse", 64'(bus.o_err), 64'd0);
    check("idle_after_timeout", 64'(bus.o_busy), 64'd0);
    bus.i_sync_ready = 1'b1;
    wait_valid(c);
    check("served_after_timeout", 64'(c), 64'd1);
    bus.i_req = '0;
    @(negedge clk);
    bus.i_sync_ready = 1'b0;
    @(negedge clk);
    bus.i_sync_ready = 1'b1;
    wait_idle();
    model_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
